// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests, stalls upstream while a request is in flight,
// detects misaligned accesses and request timeouts, and loads the MEM/WB register.
module mem_access_stage (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        RegWrite_MEM,
  input  logic        MemtoReg_MEM,
  input  logic        Branch_MEM,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic        Zero_MEM,
  input  logic [31:0] Branch_Dest_MEM,
  input  logic [31:0] ALU_Result_MEM,
  input  logic [31:0] Write_Data_MEM,
  input  logic [4:0]  Write_Register_MEM,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_Wdata,
  input  logic [31:0] Mem_Rdata,
  input  logic        Mem_Ack,
  output logic        PCSrc_MEM,
  output logic [31:0] Branch_Target_MEM,
  output logic        Stall_MEM,
  output logic        RegWrite_WB,
  output logic        MemtoReg_WB,
  output logic [31:0] Read_Data_WB,
  output logic [31:0] ALU_Result_WB,
  output logic [4:0]  Write_Register_WB,
  output logic        Align_Error,
  output logic        Mem_Timeout
);

  typedef enum logic [0:0] {StIdle, StBusy} state_t;

  state_t      r_state, w_state_d;
  logic [3:0]  r_wait_cnt, w_wait_cnt_d;

  logic        r_mem_req, r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata;

  // Controls of the instruction that owns the in-flight request
  logic        r_lat_rw, r_lat_m2r;
  logic [4:0]  r_lat_rd;

  logic        r_wb_rw, r_wb_m2r;
  logic [31:0] r_wb_data, r_wb_alu;
  logic [4:0]  r_wb_rd;
  logic        r_align_err, r_timeout;

  logic        w_access, w_misaligned, w_stall, w_latch_txn, w_align_d, w_timeout_d;
  logic        w_wb_rw_d, w_wb_m2r_d;
  logic [31:0] w_wb_data_d, w_wb_alu_d;
  logic [4:0]  w_wb_rd_d;

  assign w_access     = MemRead_MEM | MemWrite_MEM;
  assign w_misaligned = ALU_Result_MEM[1:0] != 2'b00;

  always_comb begin
    w_state_d    = r_state;
    w_wait_cnt_d = r_wait_cnt;
    w_stall      = 1'b0;
    w_latch_txn  = 1'b0;
    w_align_d    = 1'b0;
    w_timeout_d  = 1'b0;
    // Bubble unless a branch below retires an instruction
    w_wb_rw_d    = 1'b0;
    w_wb_m2r_d   = 1'b0;
    w_wb_data_d  = 32'd0;
    w_wb_alu_d   = 32'd0;
    w_wb_rd_d    = 5'd0;
    case (r_state)
      StIdle: begin
        w_wait_cnt_d = 4'd0;
        if (!w_access) begin
          w_wb_rw_d  = RegWrite_MEM;
          w_wb_m2r_d = MemtoReg_MEM;
          w_wb_alu_d = ALU_Result_MEM;
          w_wb_rd_d  = Write_Register_MEM;
        end else if (w_misaligned) begin
          w_align_d = 1'b1;
        end else begin
          w_stall     = 1'b1;
          w_latch_txn = 1'b1;
          w_state_d   = StBusy;
        end
      end
      StBusy: begin
        if (Mem_Ack) begin
          w_state_d   = StIdle;
          w_wb_rw_d   = r_lat_rw;
          w_wb_m2r_d  = r_lat_m2r;
          w_wb_alu_d  = r_mem_addr;
          w_wb_rd_d   = r_lat_rd;
          w_wb_data_d = r_mem_we ? 32'd0 : Mem_Rdata;
        end else if (r_wait_cnt == 4'd15) begin
          w_state_d   = StIdle;
          w_timeout_d = 1'b1;
        end else begin
          w_stall      = 1'b1;
          w_wait_cnt_d = r_wait_cnt + 4'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= StIdle;
      r_wait_cnt  <= 4'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_lat_rw    <= 1'b0;
      r_lat_m2r   <= 1'b0;
      r_lat_rd    <= 5'd0;
      r_wb_rw     <= 1'b0;
      r_wb_m2r    <= 1'b0;
      r_wb_data   <= 32'd0;
      r_wb_alu    <= 32'd0;
      r_wb_rd     <= 5'd0;
      r_align_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_wait_cnt  <= w_wait_cnt_d;
      r_mem_req   <= (w_state_d == StBusy);
      r_wb_rw     <= w_wb_rw_d;
      r_wb_m2r    <= w_wb_m2r_d;
      r_wb_data   <= w_wb_data_d;
      r_wb_alu    <= w_wb_alu_d;
      r_wb_rd     <= w_wb_rd_d;
      r_align_err <= w_align_d;
      r_timeout   <= w_timeout_d;
      if (r_state == StIdle) begin
        r_lat_rw  <= RegWrite_MEM;
        r_lat_m2r <= MemtoReg_MEM;
        r_lat_rd  <= Write_Register_MEM;
      end
      if (w_latch_txn) begin
        r_mem_addr  <= ALU_Result_MEM;
        r_mem_wdata <= Write_Data_MEM;
        r_mem_we    <= MemWrite_MEM & ~MemRead_MEM;
      end
    end
  end

  assign Mem_Req           = r_mem_req;
  assign Mem_We            = r_mem_we;
  assign Mem_Addr          = r_mem_addr;
  assign Mem_Wdata         = r_mem_wdata;
  assign Stall_MEM         = w_stall & ~Reset;
  assign PCSrc_MEM         = Branch_MEM & Zero_MEM & (r_state == StIdle) & ~Reset;
  assign Branch_Target_MEM = Branch_Dest_MEM;
  assign RegWrite_WB       = r_wb_rw;
  assign MemtoReg_WB       = r_wb_m2r;
  assign Read_Data_WB      = r_wb_data;
  assign ALU_Result_WB     = r_wb_alu;
  assign Write_Register_WB = r_wb_rd;
  assign Align_Error       = r_align_err;
  assign Mem_Timeout       = r_timeout;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: driver issues instructions and a memory responder,
// a monitor compares each retired MEM/WB value against an instruction-level model.
module tb_mem_access_stage;

  logic        Clk, Reset;
  logic        RegWrite_MEM, MemtoReg_MEM, Branch_MEM, MemRead_MEM, MemWrite_MEM, Zero_MEM;
  logic [31:0] Branch_Dest_MEM, ALU_Result_MEM, Write_Data_MEM;
  logic [4:0]  Write_Register_MEM;
  logic        Mem_Req, Mem_We, Mem_Ack;
  logic [31:0] Mem_Addr, Mem_Wdata, Mem_Rdata;
  logic        PCSrc_MEM, Stall_MEM;
  logic [31:0] Branch_Target_MEM, Read_Data_WB, ALU_Result_WB;
  logic        RegWrite_WB, MemtoReg_WB, Align_Error, Mem_Timeout;
  logic [4:0]  Write_Register_WB;

  mem_access_stage dut (
    .Clk(Clk), .Reset(Reset),
    .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM), .Branch_MEM(Branch_MEM),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .Zero_MEM(Zero_MEM),
    .Branch_Dest_MEM(Branch_Dest_MEM), .ALU_Result_MEM(ALU_Result_MEM),
    .Write_Data_MEM(Write_Data_MEM), .Write_Register_MEM(Write_Register_MEM),
    .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
    .Mem_Rdata(Mem_Rdata), .Mem_Ack(Mem_Ack),
    .PCSrc_MEM(PCSrc_MEM), .Branch_Target_MEM(Branch_Target_MEM), .Stall_MEM(Stall_MEM),
    .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB), .Read_Data_WB(Read_Data_WB),
    .ALU_Result_WB(ALU_Result_WB), .Write_Register_WB(Write_Register_WB),
    .Align_Error(Align_Error), .Mem_Timeout(Mem_Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic rw, m2r, br, z, mr, mw, stray;
    logic [31:0] dest, alu, wd, rdata;
    logic [4:0] rd;
    int ack;  // BUSY cycle (1-based) carrying Mem_Ack; 0 means never
  } ins_t;

  typedef struct {
    logic bubble, align, tmo, rw, m2r;
    logic [4:0] rd;
    logic [31:0] alu, data;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic acked(input ins_t in);
    return in.ack >= 1 && in.ack <= 16;
  endfunction

  function automatic logic aligned_access(input ins_t in);
    return (in.mr | in.mw) && in.alu[1:0] == 2'b00;
  endfunction

  function automatic exp_t model(input ins_t in);
    exp_t e;
    e = '{bubble: 1'b1, align: 1'b0, tmo: 1'b0, rw: 1'b0, m2r: 1'b0, rd: 5'd0,
          alu: 32'd0, data: 32'd0};
    if (!(in.mr | in.mw) || (aligned_access(in) && acked(in))) begin
      e.bubble = 1'b0;
      e.rw = in.rw;  e.m2r = in.m2r;  e.rd = in.rd;  e.alu = in.alu;
      e.data = (in.mr && aligned_access(in)) ? in.rdata : 32'd0;
    end else if (!aligned_access(in)) begin
      e.align = 1'b1;
    end else begin
      e.tmo = 1'b1;
    end
    return e;
  endfunction

  // IDLE cycle stalls, then BUSY cycles up to (not including) the ack or timeout cycle
  function automatic int exp_stalls(input ins_t in);
    if (!aligned_access(in)) return 0;
    return acked(in) ? in.ack : 16;
  endfunction

  task automatic do_instr(input ins_t in);
    int k;
    int stalls;
    @(posedge Clk); #1;
    Reset = 1'b0;
    RegWrite_MEM = in.rw;  MemtoReg_MEM = in.m2r;  Branch_MEM = in.br;  Zero_MEM = in.z;
    MemRead_MEM = in.mr;   MemWrite_MEM = in.mw;   Branch_Dest_MEM = in.dest;
    ALU_Result_MEM = in.alu;  Write_Data_MEM = in.wd;  Write_Register_MEM = in.rd;
    Mem_Ack = in.stray;  Mem_Rdata = $urandom;
    stalls = 0;
    k = 0;
    @(negedge Clk);
    chk("idle_mem_req", {31'd0, Mem_Req}, 32'd0);
    chk("pcsrc_idle", {31'd0, PCSrc_MEM}, {31'd0, in.br & in.z});
    chk("branch_target", Branch_Target_MEM, in.dest);
    if (Stall_MEM) stalls++;
    while (Stall_MEM && k < 20) begin
      @(posedge Clk); #1;
      k++;
      Mem_Ack = (k == in.ack);
      Mem_Rdata = (k == in.ack) ? in.rdata : $urandom;
      chk("busy_req_addr_wdata_we", {Mem_Req, Mem_We, Mem_Addr[29:0]},
          {1'b1, in.mw & ~in.mr, in.alu[29:0]});
      chk("busy_wdata", Mem_Wdata, in.wd);
      @(negedge Clk);
      chk("pcsrc_busy", {31'd0, PCSrc_MEM}, 32'd0);
      if (Stall_MEM) stalls++;
    end
    if (Stall_MEM) begin
      errors++;
      $display("FAIL stall_bound: Stall_MEM still 1 after %0d BUSY cycles, required 0", k);
      $display("Result: errors=%0d of %0d checks", errors, checks + 1);
      $fatal(1, "stall never released");
    end
    chk("stall_cycles", stalls, exp_stalls(in));
    sb.push_back(model(in));
  endtask

  function automatic ins_t nop();
    ins_t n;
    n = '{rw: 1'b0, m2r: 1'b0, br: 1'b0, z: 1'b0, mr: 1'b0, mw: 1'b0, stray: 1'b0,
          dest: 32'd0, alu: 32'd0, wd: 32'd0, rdata: 32'd0, rd: 5'd0, ack: 0};
    return n;
  endfunction

  function automatic ins_t rand_ins();
    ins_t n;
    int r;
    n = nop();
    n.rw = 1'($urandom);  n.m2r = 1'($urandom);  n.br = 1'($urandom);  n.z = 1'($urandom);
    r = $urandom_range(0, 3);
    n.mr = (r == 1) || (r == 3);
    n.mw = (r == 2) || (r == 3);
    n.dest = $urandom;  n.wd = $urandom;  n.rdata = $urandom;  n.rd = 5'($urandom);
    n.alu = $urandom;
    if ($urandom_range(0, 4) != 0) n.alu[1:0] = 2'b00;
    n.stray = 1'($urandom);
    r = $urandom_range(0, 11);
    n.ack = (r == 0) ? 0 : (r == 1) ? 16 : $urandom_range(1, 4);
    return n;
  endfunction

  // Monitor: a cycle accepted by the stage retires into MEM/WB one edge later
  initial begin
    bit   pa, ps;
    exp_t e;
    pa = 1'b0;
    ps = 1'b0;
    forever begin
      @(negedge Clk);
      if (pa) begin
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL sb_underflow: MEM/WB update with no expected entry");
        end else begin
          e = sb.pop_front();
          chk("wb_regwrite", {31'd0, RegWrite_WB}, {31'd0, e.rw});
          chk("align_error", {31'd0, Align_Error}, {31'd0, e.align});
          chk("mem_timeout", {31'd0, Mem_Timeout}, {31'd0, e.tmo});
          if (!e.bubble) begin
            chk("wb_memtoreg", {31'd0, MemtoReg_WB}, {31'd0, e.m2r});
            chk("wb_rd", {27'd0, Write_Register_WB}, {27'd0, e.rd});
            chk("wb_alu", ALU_Result_WB, e.alu);
            chk("wb_read_data", Read_Data_WB, e.data);
          end
        end
      end else if (ps) begin
        chk("stall_bubble", {29'd0, RegWrite_WB, Align_Error, Mem_Timeout}, 32'd0);
      end
      pa = !Reset && !Stall_MEM;
      ps = !Reset && Stall_MEM;
    end
  end

  initial begin
    ins_t in;
    Reset = 1'b1;
    {RegWrite_MEM, MemtoReg_MEM, Branch_MEM, MemRead_MEM, MemWrite_MEM, Zero_MEM} = '0;
    Branch_Dest_MEM = '0;  ALU_Result_MEM = '0;  Write_Data_MEM = '0;  Write_Register_MEM = '0;
    Mem_Ack = 1'b0;  Mem_Rdata = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_mem", {Mem_Req, Mem_We, Mem_Addr[29:0]} | Mem_Wdata, 32'd0);
    chk("reset_wb", {RegWrite_WB, MemtoReg_WB, Align_Error, Mem_Timeout, 23'd0,
                     Write_Register_WB} | Read_Data_WB | ALU_Result_WB, 32'd0);
    chk("reset_stall_pcsrc", {30'd0, Stall_MEM, PCSrc_MEM}, 32'd0);

    in = nop();  in.rw = 1'b1;  in.alu = 32'h10;  in.rd = 5'd5;
    do_instr(in);
    in = nop();  in.rw = 1'b1;  in.m2r = 1'b1;  in.mr = 1'b1;  in.alu = 32'h100;  in.rd = 5'd7;
    in.ack = 3;  in.rdata = 32'hDEADBEEF;
    do_instr(in);
    in = nop();  in.mw = 1'b1;  in.alu = 32'h200;  in.wd = 32'h55;  in.ack = 1;
    do_instr(in);
    in = nop();  in.rw = 1'b1;  in.mr = 1'b1;  in.alu = 32'h102;  in.rd = 5'd3;  in.ack = 1;
    do_instr(in);
    in = nop();  in.rw = 1'b1;  in.mr = 1'b1;  in.alu = 32'h104;  in.rd = 5'd9;  in.ack = 0;
    do_instr(in);
    in = nop();  in.rw = 1'b1;  in.mr = 1'b1;  in.alu = 32'h108;  in.rd = 5'd4;  in.ack = 16;
    in.rdata = 32'h1234_5678;
    do_instr(in);
    in = nop();  in.br = 1'b1;  in.z = 1'b1;  in.dest = 32'h40;  in.stray = 1'b1;
    do_instr(in);

    // Reset during a BUSY load abandons it; a late ack afterwards is ignored
    @(posedge Clk); #1;
    RegWrite_MEM = 1'b1;  MemRead_MEM = 1'b1;  MemWrite_MEM = 1'b0;  Branch_MEM = 1'b0;
    ALU_Result_MEM = 32'h300;  Mem_Ack = 1'b0;
    @(negedge Clk);
    chk("rst_busy_stall", {31'd0, Stall_MEM}, 32'd1);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(negedge Clk);
    chk("rst_stall_forced", {30'd0, Stall_MEM, PCSrc_MEM}, 32'd0);
    @(posedge Clk); #1;
    chk("rst_busy_mem", {Mem_Req, Mem_We, Mem_Addr[29:0]} | Mem_Wdata, 32'd0);
    chk("rst_busy_wb", {RegWrite_WB, MemtoReg_WB, Align_Error, Mem_Timeout, 23'd0,
                        Write_Register_WB} | Read_Data_WB | ALU_Result_WB, 32'd0);
    in = nop();  in.rw = 1'b1;  in.alu = 32'h77;  in.rd = 5'd2;  in.stray = 1'b1;
    do_instr(in);
    in = nop();
    do_instr(in);

    for (int i = 0; i < 60; i++) do_instr(rand_ins());

    @(posedge Clk); #1;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have inputs RegWrite_MEM, MemtoReg_MEM, Branch_MEM, MemRead_MEM, MemWrite_MEM, Zero_MEM, each 1 bit: control and flag fields from the EX/MEM register.
REQ-004 SHALL have inputs Branch_Dest_MEM, ALU_Result_MEM and Write_Data_MEM, each 32 bits, and input Write_Register_MEM, 5 bits.
REQ-005 SHALL have outputs Mem_Req (1 bit), Mem_We (1 bit), Mem_Addr (32 bits) and Mem_Wdata (32 bits): data-memory request port.
REQ-006 SHALL have inputs Mem_Rdata (32 bits) and Mem_Ack (1 bit): data-memory response port.
REQ-007 SHALL have outputs PCSrc_MEM (1 bit) and Branch_Target_MEM (32 bits): branch redirect to fetch.
REQ-008 SHALL have output Stall_MEM, 1 bit: holds the EX/MEM register and all upstream stages.
REQ-009 SHALL have outputs RegWrite_WB, MemtoReg_WB (1 bit each), Read_Data_WB and ALU_Result_WB (32 bits each) and Write_Register_WB (5 bits): the MEM/WB register.
REQ-010 SHALL have outputs Align_Error and Mem_Timeout, 1 bit each: one-cycle fault pulses.

Function
REQ-011 SHALL implement the FSM states IDLE and BUSY, plus a 4-bit wait counter Wait_Cnt.
REQ-012 SHALL define access = MemRead_MEM | MemWrite_MEM; a read SHALL take priority if both are set.
REQ-013 SHALL define misaligned = ALU_Result_MEM[1:0] != 0.
REQ-014 In IDLE with no access, SHALL load the MEM/WB register at the next edge from the MEM inputs and set Read_Data_WB = 0, giving 1-cycle latency.
REQ-015 In IDLE with access and misaligned, SHALL issue no request and pulse Align_Error for one cycle.
REQ-016 In that misaligned case, SHALL load a bubble into MEM/WB (RegWrite_WB = 0) and SHALL NOT stall.
REQ-017 In IDLE with an aligned access, SHALL hold Stall_MEM = 1, load a bubble into MEM/WB, latch the transaction into the Mem_* registers and move to BUSY.
REQ-018 The latched transaction SHALL be: Mem_Addr = ALU_Result_MEM, Mem_Wdata = Write_Data_MEM, Mem_We = MemWrite_MEM & ~MemRead_MEM.
REQ-019 In IDLE, SHALL also latch RegWrite_MEM, MemtoReg_MEM and Write_Register_MEM internally and clear Wait_Cnt.
REQ-020 In BUSY, Mem_Req SHALL be 1 and the Mem_* outputs SHALL stay stable until Mem_Ack or timeout.
REQ-021 In BUSY with Mem_Ack = 0, SHALL hold Stall_MEM = 1, increment Wait_Cnt and keep loading a bubble into MEM/WB.
REQ-022 In BUSY with Mem_Ack = 1, SHALL drop Stall_MEM to 0 in that same cycle and return to IDLE at the next edge.
REQ-023 On that acknowledge edge, SHALL load MEM/WB from the latched controls, with Read_Data_WB = Mem_Rdata for reads and 0 for writes.
REQ-024 In BUSY with Mem_Ack = 0 and Wait_Cnt = 15, SHALL drop Stall_MEM to 0, pulse Mem_Timeout for one cycle, load a bubble and return to IDLE.
REQ-025 If Mem_Ack and timeout occur in the same cycle, the acknowledge SHALL win.
REQ-026 Mem_Req SHALL be registered (Mem_Req = state is BUSY) and SHALL drop on the edge that leaves BUSY.
REQ-027 Mem_Ack received in IDLE SHALL be ignored.
REQ-028 Stall_MEM SHALL be combinational: (IDLE & access & ~misaligned) | (BUSY & ~Mem_Ack & Wait_Cnt != 15), forced to 0 while Reset = 1.
REQ-029 PCSrc_MEM SHALL be combinational: Branch_MEM & Zero_MEM & state is IDLE & ~Reset.
REQ-030 Branch_Target_MEM SHALL equal Branch_Dest_MEM.
REQ-031 Arithmetic: Wait_Cnt SHALL saturate at 15 and SHALL never wrap.
REQ-032 Arithmetic: no sign or width conversion SHALL occur on data paths.
REQ-033 Align_Error and Mem_Timeout SHALL be registered, each high for exactly one cycle.

Reset
REQ-034 On a Clk edge with Reset = 1, state SHALL become IDLE and Wait_Cnt SHALL become 0.
REQ-035 On that edge, Mem_Req, Mem_We, Mem_Addr, Mem_Wdata and every MEM/WB output SHALL become 0.
REQ-036 On that edge, Align_Error and Mem_Timeout SHALL become 0.
REQ-037 Reset asserted while in BUSY SHALL abandon the transaction: Mem_Req is 0 after that edge, and a late Mem_Ack is ignored.

Verification
REQ-038 Bench SHALL cover ALU op: RegWrite_MEM = 1, ALU_Result_MEM = 0x10, Write_Register_MEM = 5, no access -> next cycle RegWrite_WB = 1, ALU_Result_WB = 0x10, Write_Register_WB = 5, Stall_MEM = 0 throughout.
REQ-039 Bench SHALL cover load: MemRead_MEM = 1, address 0x100, Mem_Ack returned on the 3rd BUSY cycle with Mem_Rdata = 0xDEADBEEF -> Stall_MEM high for 3 cycles, Mem_Addr = 0x100, then Read_Data_WB = 0xDEADBEEF and MemtoReg_WB = 1.
REQ-040 Bench SHALL cover store: MemWrite_MEM = 1, Write_Data_MEM = 0x55, Mem_Ack immediate -> Mem_We = 1 and Mem_Wdata = 0x55 for one BUSY cycle; RegWrite_WB follows RegWrite_MEM (0 for a store).
REQ-041 Bench SHALL cover misaligned load at address 0x102 -> Align_Error pulses once, Mem_Req never rises, RegWrite_WB = 0, no stall.
REQ-042 Bench SHALL cover timeout: load with Mem_Ack held at 0 -> Mem_Timeout pulses after 16 BUSY cycles, Stall_MEM falls, a bubble is written, state returns to IDLE.
REQ-043 Bench SHALL cover branch with Branch_MEM = 1, Zero_MEM = 1, Branch_Dest_MEM = 0x40 -> PCSrc_MEM = 1, Branch_Target_MEM = 0x40; then Reset asserted during a BUSY load -> Mem_Req = 0 next cycle and all outputs 0.
